// File: rtl/fft_pkg.sv
// fft_pkg: constants and types shared by the FFT result reader.
//   NUM_BANKS  number of fft_top result banks
//   FFT_N      total result words per readout
//   IDX_W      width of a spectral index k
//   rr_state_t reader FSM state, with the constants IDLE / ISSUE / DRAIN
package fft_pkg;

    localparam int unsigned NUM_BANKS  = 4;
    localparam int unsigned FFT_N      = 2048;
    localparam int unsigned IDX_W      = $clog2(FFT_N);
    localparam int unsigned BANK_SEL_W = $clog2(NUM_BANKS);

    typedef logic [BANK_SEL_W-1:0] bank_sel_t;

    typedef logic [1:0] rr_state_t;
    localparam rr_state_t IDLE  = 2'd0;
    localparam rr_state_t ISSUE = 2'd1;
    localparam rr_state_t DRAIN = 2'd2;

endpackage

// File: rtl/fft_rd_skid.sv
// fft_rd_skid: small synchronous FIFO with occupancy output.
//   iCLK, iRESET  clock, asynchronous active-low reset
//   iPUSH, iDATA  write strobe and word (ignored when full and not popping)
//   iPOP          read strobe (ignored when empty)
//   oDATA         head word (valid while oEMPTY is low)
//   oEMPTY        no entries held
//   oCOUNT        number of entries held
module fft_rd_skid #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned W     = 8
) (
    input  logic                         iCLK,
    input  logic                         iRESET,
    input  logic                         iPUSH,
    input  logic [W-1:0]                 iDATA,
    input  logic                         iPOP,
    output logic [W-1:0]                 oDATA,
    output logic                         oEMPTY,
    output logic [$clog2(DEPTH+1)-1:0]   oCOUNT
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop  = iPOP & (count_q != '0);
    assign do_push = iPUSH & ((count_q != CNT_W'(DEPTH)) | do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = iDATA;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign oDATA  = mem_q[rd_ptr_q];
    assign oEMPTY = (count_q == '0);
    assign oCOUNT = count_q;

endmodule

// File: rtl/fft_result_reader.sv
// fft_result_reader: drains fft_top's four real-part result banks after oRDY rises and
// streams every word out on a valid/ready interface with its spectral index.
//   iCLK, iRESET          clock, asynchronous active-low reset
//   iFFT_RDY              fft_top oRDY; each rising edge starts one readout
//   oADDR_RD_0..3         common read address to all four banks
//   iDATA_RE_0..3         bank read data, RD_LAT clocks after the address
//   oDATA/oINDEX/oLAST    stream payload: word, index k, final-beat flag
//   oVALID/iREADY         stream handshake
//   oBUSY                 readout in progress
//   oDONE                 one-clock pulse after the final beat is accepted
//   oOVR                  one-clock pulse when a start edge arrives while busy
module fft_result_reader
    import fft_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned ORDER  = 1
) (
    input  logic                iCLK,
    input  logic                iRESET,
    input  logic                iFFT_RDY,
    output logic [ADDR_W-1:0]   oADDR_RD_0,
    output logic [ADDR_W-1:0]   oADDR_RD_1,
    output logic [ADDR_W-1:0]   oADDR_RD_2,
    output logic [ADDR_W-1:0]   oADDR_RD_3,
    input  logic [DATA_W-1:0]   iDATA_RE_0,
    input  logic [DATA_W-1:0]   iDATA_RE_1,
    input  logic [DATA_W-1:0]   iDATA_RE_2,
    input  logic [DATA_W-1:0]   iDATA_RE_3,
    output logic [DATA_W-1:0]   oDATA,
    output logic [ADDR_W+1:0]   oINDEX,
    output logic                oVALID,
    input  logic                iREADY,
    output logic                oLAST,
    output logic                oBUSY,
    output logic                oDONE,
    output logic                oOVR
);

    localparam int unsigned K_W    = ADDR_W + 2;
    localparam int unsigned FIFO_D = RD_LAT + 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_D + 1);
    localparam int unsigned ENT_W  = K_W + DATA_W;
    localparam logic [K_W-1:0] K_LAST = {K_W{1'b1}};

    rr_state_t        state_q, state_d;
    logic             rdy_q, rdy_qq;
    logic             start;
    logic [K_W-1:0]   rd_k_q, rd_k_d;
    logic             done_q, done_d;
    logic             ovr_q, ovr_d;

    // Read pipe: tracks each issued read until its bank data is valid.
    logic [RD_LAT-1:0] pipe_vld_q, pipe_vld_d;
    logic [K_W-1:0]    pipe_k_q    [RD_LAT];
    logic [K_W-1:0]    pipe_k_d    [RD_LAT];
    bank_sel_t         pipe_bank_q [RD_LAT];
    bank_sel_t         pipe_bank_d [RD_LAT];

    logic [ADDR_W-1:0] rd_addr;
    bank_sel_t         rd_bank;
    logic              issue;
    logic [CNT_W-1:0]  inflight;
    logic [CNT_W:0]    occupancy;

    logic              fifo_push, fifo_pop, fifo_empty;
    logic [ENT_W-1:0]  fifo_wdata, fifo_rdata;
    logic [CNT_W-1:0]  fifo_count;
    logic [DATA_W-1:0] push_data;
    logic              beat_last;

    // iFFT_RDY is registered first, so start is a clean one-clock edge pulse.
    assign start = rdy_q & ~rdy_qq;

    always_comb begin
        if (ORDER != 0) begin
            rd_addr = rd_k_q[K_W-1:2];
            rd_bank = rd_k_q[1:0];
        end else begin
            rd_addr = rd_k_q[ADDR_W-1:0];
            rd_bank = rd_k_q[K_W-1:ADDR_W];
        end
    end

    assign oADDR_RD_0 = rd_addr;
    assign oADDR_RD_1 = rd_addr;
    assign oADDR_RD_2 = rd_addr;
    assign oADDR_RD_3 = rd_addr;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < int'(RD_LAT); i++) begin
            inflight = inflight + CNT_W'(pipe_vld_q[i]);
        end
    end

    // Every issued read owns a FIFO slot, so the FIFO can never overflow; a pop this
    // cycle frees a slot, which is what keeps the stream at full rate.
    assign occupancy = {1'b0, fifo_count} + {1'b0, inflight} - (CNT_W + 1)'(fifo_pop);
    assign issue     = (state_q == ISSUE) && (occupancy < (CNT_W + 1)'(FIFO_D));

    always_comb begin
        pipe_vld_d[0]  = issue;
        pipe_k_d[0]    = rd_k_q;
        pipe_bank_d[0] = rd_bank;
        for (int i = 1; i < int'(RD_LAT); i++) begin
            pipe_vld_d[i]  = pipe_vld_q[i-1];
            pipe_k_d[i]    = pipe_k_q[i-1];
            pipe_bank_d[i] = pipe_bank_q[i-1];
        end
    end

    always_comb begin
        unique case (pipe_bank_q[RD_LAT-1])
            2'd0:    push_data = iDATA_RE_0;
            2'd1:    push_data = iDATA_RE_1;
            2'd2:    push_data = iDATA_RE_2;
            default: push_data = iDATA_RE_3;
        endcase
    end

    assign fifo_push  = pipe_vld_q[RD_LAT-1];
    assign fifo_wdata = {pipe_k_q[RD_LAT-1], push_data};
    assign fifo_pop   = oVALID & iREADY;
    assign beat_last  = fifo_pop & oLAST;

    fft_rd_skid #(
        .DEPTH (FIFO_D),
        .W     (ENT_W)
    ) u_skid (
        .iCLK   (iCLK),
        .iRESET (iRESET),
        .iPUSH  (fifo_push),
        .iDATA  (fifo_wdata),
        .iPOP   (fifo_pop),
        .oDATA  (fifo_rdata),
        .oEMPTY (fifo_empty),
        .oCOUNT (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        rd_k_d  = rd_k_q;
        done_d  = 1'b0;
        ovr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ISSUE;
                    rd_k_d  = '0;
                end
            end
            ISSUE: begin
                ovr_d = start;
                if (issue) begin
                    if (rd_k_q == K_LAST) begin
                        state_d = DRAIN;
                    end else begin
                        rd_k_d = rd_k_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (beat_last) begin
                    done_d = 1'b1;
                    // A start coinciding with completion begins the next readout.
                    if (start) begin
                        state_d = ISSUE;
                        rd_k_d  = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    ovr_d = start;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state_q    <= IDLE;
            rdy_q      <= 1'b0;
            rdy_qq     <= 1'b0;
            rd_k_q     <= '0;
            done_q     <= 1'b0;
            ovr_q      <= 1'b0;
            pipe_vld_q <= '0;
            for (int i = 0; i < int'(RD_LAT); i++) begin
                pipe_k_q[i]    <= '0;
                pipe_bank_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            rdy_q      <= iFFT_RDY;
            rdy_qq     <= rdy_q;
            rd_k_q     <= rd_k_d;
            done_q     <= done_d;
            ovr_q      <= ovr_d;
            pipe_vld_q <= pipe_vld_d;
            pipe_k_q   <= pipe_k_d;
            pipe_bank_q <= pipe_bank_d;
        end
    end

    assign oVALID = ~fifo_empty;
    assign oINDEX = fifo_rdata[ENT_W-1:DATA_W];
    assign oDATA  = fifo_rdata[DATA_W-1:0];
    assign oLAST  = oVALID & (oINDEX == K_LAST);
    assign oBUSY  = (state_q != IDLE);
    assign oDONE  = done_q;
    assign oOVR   = ovr_q;

endmodule

// File: tb/tb_fft_result_reader.sv
// Bench for fft_result_reader: three instances (ORDER=1/RD_LAT=1, ORDER=0/RD_LAT=1,
// ORDER=1/RD_LAT=2) share trigger, reset and ready; each sees its own bank model.
module tb_fft_result_reader;

    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, rdy, ready, rand_mode, clr_req;
    int   cyc = 0;
    int   nvec = 0;
    int   nerr = 0;
    int   nstall = 0;

    logic [8:0]  addr  [NI][4];
    logic [15:0] bdata [NI][4];
    logic [15:0] odata [NI];
    logic [10:0] oidx  [NI];
    logic        ovalid[NI], olast[NI], obusy[NI], odone[NI], oovr[NI];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int ord_of(input int i);
        return (i == 1) ? 0 : 1;
    endfunction

    function automatic int lat_of(input int i);
        return (i == 2) ? 2 : 1;
    endfunction

    function automatic logic [15:0] bank_val(input int b, input logic [8:0] a);
        return {4'h0, 2'(b), 1'b0, a} + 16'h1000;
    endfunction

    // Word k must come from this bank/address under the given ordering.
    function automatic logic [15:0] exp_val(input int order, input int k);
        if (order != 0) return bank_val(k % 4, 9'(k / 4));
        return bank_val(k / 512, 9'(k % 512));
    endfunction

    task automatic chk(input string name, input int act, input int req);
        nvec++;
        if (act != req) begin
            nerr++;
            if (nerr < 40) $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int LAT = (g == 2) ? 2 : 1;
        for (genvar b = 0; b < 4; b++) begin : g_bank
            logic [8:0] ap1, ap2;
            always @(posedge clk) begin
                ap1 <= addr[g][b];
                ap2 <= ap1;
            end
            assign bdata[g][b] = bank_val(b, (LAT == 2) ? ap2 : ap1);
        end
        fft_result_reader #(
            .DATA_W (16),
            .ADDR_W (9),
            .RD_LAT (LAT),
            .ORDER  ((g == 1) ? 0 : 1)
        ) u_dut (
            .iCLK       (clk),
            .iRESET     (rst_n),
            .iFFT_RDY   (rdy),
            .oADDR_RD_0 (addr[g][0]),
            .oADDR_RD_1 (addr[g][1]),
            .oADDR_RD_2 (addr[g][2]),
            .oADDR_RD_3 (addr[g][3]),
            .iDATA_RE_0 (bdata[g][0]),
            .iDATA_RE_1 (bdata[g][1]),
            .iDATA_RE_2 (bdata[g][2]),
            .iDATA_RE_3 (bdata[g][3]),
            .oDATA      (odata[g]),
            .oINDEX     (oidx[g]),
            .oVALID     (ovalid[g]),
            .iREADY     (ready),
            .oLAST      (olast[g]),
            .oBUSY      (obusy[g]),
            .oDONE      (odone[g]),
            .oOVR       (oovr[g])
        );
    end

    // Scoreboard state, written only by the compare process.
    int          exp_k[NI], nbeat[NI], ndone[NI], novr[NI], first_cyc[NI], last_cyc[NI];
    logic        held[NI], hl[NI];
    logic [15:0] hd[NI];
    logic [10:0] hi[NI];
    logic [15:0] pin0_k0, pin0_k5, pin1_k512, pin1_k2047, pin2_k6;

    always @(negedge clk) begin
        if (clr_req) begin
            for (int i = 0; i < NI; i++) begin
                exp_k[i] = 0; nbeat[i] = 0; ndone[i] = 0; novr[i] = 0;
                first_cyc[i] = -1; last_cyc[i] = -1; held[i] = 1'b0;
            end
        end else if (rst_n) begin
            for (int i = 0; i < NI; i++) begin
                for (int b = 1; b < 4; b++) chk($sformatf("i%0d.addr_eq%0d", i, b),
                                                int'(addr[i][b]), int'(addr[i][0]));
                if (ovalid[i] && first_cyc[i] < 0) first_cyc[i] = cyc;
                if (held[i]) begin
                    chk($sformatf("i%0d.stall_valid", i), int'(ovalid[i]), 1);
                    chk($sformatf("i%0d.stall_data", i), int'(odata[i]), int'(hd[i]));
                    chk($sformatf("i%0d.stall_idx", i), int'(oidx[i]), int'(hi[i]));
                    chk($sformatf("i%0d.stall_last", i), int'(olast[i]), int'(hl[i]));
                end
                if (ovalid[i] && ready) begin
                    chk($sformatf("i%0d.idx", i), int'(oidx[i]), exp_k[i]);
                    chk($sformatf("i%0d.data k=%0d", i, exp_k[i]), int'(odata[i]),
                        int'(exp_val(ord_of(i), exp_k[i])));
                    chk($sformatf("i%0d.last k=%0d", i, exp_k[i]), int'(olast[i]),
                        (exp_k[i] == 2047) ? 1 : 0);
                    if (i == 0 && exp_k[i] == 0)    pin0_k0 = odata[i];
                    if (i == 0 && exp_k[i] == 5)    pin0_k5 = odata[i];
                    if (i == 1 && exp_k[i] == 512)  pin1_k512 = odata[i];
                    if (i == 1 && exp_k[i] == 2047) pin1_k2047 = odata[i];
                    if (i == 2 && exp_k[i] == 6)    pin2_k6 = odata[i];
                    if (exp_k[i] == 2047) last_cyc[i] = cyc;
                    exp_k[i]++;
                    nbeat[i]++;
                    held[i] = 1'b0;
                end else if (ovalid[i]) begin
                    held[i] = 1'b1; hd[i] = odata[i]; hi[i] = oidx[i]; hl[i] = olast[i];
                    nstall++;
                end else begin
                    held[i] = 1'b0;
                end
                if (odone[i]) ndone[i]++;
                if (oovr[i]) novr[i]++;
            end
        end
    end

    initial begin
        ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear();
        @(posedge clk); clr_req = 1'b1;
        @(posedge clk); clr_req = 1'b0;
    endtask

    task automatic trigger(output int sc);
        @(posedge clk); #1 rdy = 1'b1;
        sc = cyc + 1;
    endtask

    task automatic wait_done(input string nm, input int budget);
        int n = 0;
        while (!(ndone[0] > 0 && ndone[1] > 0 && ndone[2] > 0) && n < budget) begin
            @(posedge clk); n++;
        end
        chk({nm, ".finished_in_budget"}, (n < budget) ? 1 : 0, 1);
        repeat (5) @(posedge clk);
    endtask

    task automatic end_checks(input string nm, input int exp_ovr);
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("%s.i%0d.beats", nm, i), nbeat[i], 2048);
            chk($sformatf("%s.i%0d.done", nm, i), ndone[i], 1);
            chk($sformatf("%s.i%0d.ovr", nm, i), novr[i], exp_ovr);
            chk($sformatf("%s.i%0d.busy_end", nm, i), int'(obusy[i]), 0);
        end
    endtask

    task automatic check_idle_zero(input string nm);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("%s.i%0d.valid", nm, i), int'(ovalid[i]), 0);
            chk($sformatf("%s.i%0d.data", nm, i), int'(odata[i]), 0);
            chk($sformatf("%s.i%0d.idx", nm, i), int'(oidx[i]), 0);
            chk($sformatf("%s.i%0d.last", nm, i), int'(olast[i]), 0);
            chk($sformatf("%s.i%0d.busy", nm, i), int'(obusy[i]), 0);
            chk($sformatf("%s.i%0d.done", nm, i), int'(odone[i]), 0);
            chk($sformatf("%s.i%0d.ovr", nm, i), int'(oovr[i]), 0);
            chk($sformatf("%s.i%0d.addr", nm, i), int'(addr[i][0]), 0);
        end
    endtask

    initial begin
        int sc;
        int n;
        rst_n = 1'b0; rdy = 1'b0; rand_mode = 1'b0; clr_req = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_idle_zero("reset");
        @(posedge clk); #1 rst_n = 1'b1;

        // Full rate, level-held trigger, all three configurations.
        clear();
        trigger(sc);
        wait_done("run1", 3000);
        end_checks("run1", 0);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("run1.i%0d.first_valid_lat", i), first_cyc[i] - sc, 2 + lat_of(i));
            chk($sformatf("run1.i%0d.last_beat_lat", i), last_cyc[i] - sc, 2049 + lat_of(i));
        end
        chk("pin.ord1_k0", int'(pin0_k0), 16'h1000);
        chk("pin.ord1_k5", int'(pin0_k5), 16'h1401);
        chk("pin.ord0_k512", int'(pin1_k512), 16'h1400);
        chk("pin.ord0_k2047", int'(pin1_k2047), 16'h1DFF);
        chk("pin.lat2_k6", int'(pin2_k6), 16'h1801);
        #1 rdy = 1'b0;

        // Random back-pressure.
        clear();
        rand_mode = 1'b1;
        trigger(sc);
        repeat (3) @(posedge clk);
        #1 rdy = 1'b0;
        wait_done("run2", 10000);
        rand_mode = 1'b0;
        end_checks("run2", 0);
        chk("run2.stalls_seen", (nstall > 0) ? 1 : 0, 1);

        // Retrigger while busy.
        clear();
        trigger(sc);
        repeat (3) @(posedge clk);
        #1 rdy = 1'b0;
        n = 0;
        while (exp_k[0] < 100 && n < 500) begin @(posedge clk); n++; end
        chk("run3.reached_beat100", (n < 500) ? 1 : 0, 1);
        #1 rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1 rdy = 1'b0;
        wait_done("run3", 3000);
        end_checks("run3", 1);

        // Reset mid-readout, then restart.
        clear();
        trigger(sc);
        repeat (3) @(posedge clk);
        #1 rdy = 1'b0;
        n = 0;
        while (exp_k[0] < 700 && n < 1500) begin @(posedge clk); n++; end
        chk("run4.reached_beat700", (n < 1500) ? 1 : 0, 1);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check_idle_zero("mid_reset");
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("post_reset.i%0d.no_done", i), ndone[i], 0);
            chk($sformatf("post_reset.i%0d.idle", i), int'(obusy[i]), 0);
            chk($sformatf("post_reset.i%0d.no_valid", i), int'(ovalid[i]), 0);
        end
        clear();
        trigger(sc);
        repeat (3) @(posedge clk);
        #1 rdy = 1'b0;
        wait_done("run5", 3000);
        end_checks("run5", 0);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("run5.i%0d.first_valid_lat", i), first_cyc[i] - sc, 2 + lat_of(i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
